id_ex_reg: RTL and testbench
============================

# id_ex_reg

Decode-to-execute pipeline register for the 5-stage MIPS core. It captures the decoded control word, register-file read data, register specifiers and sign-extended immediate at the end of D. It presents them to E, along with `WriteRegE`, for ALU operand selection and forwarding/stall resolution. It consumes `FlushE` from the stall controller and inserts a bubble when a load-use hazard holds D and F. It produces the `RsE`, `RtE` and `MemtoRegE` values that the hazard logic compares against.

## Interface
Parameters:
- `DW`, 32, datapath width (RD1/RD2/SignImm).
- `RW`, 5, register specifier width.

Ports:
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `FlushE` in 1: bubble request from the stall controller.
- `ValidD` in 1: D holds a real instruction.
- `RegWriteD`, `MemtoRegD`, `MemWriteD`, `ALUSrcD`, `RegDstD` in 1 each: decoded control.
- `ALUControlD` in 3: ALU operation.
- `RD1D`, `RD2D` in DW: register-file read data.
- `SignImmD` in DW: sign-extended immediate.
- `RsD`, `RtD`, `RdD` in RW: instruction register fields.
- `RegWriteE`, `MemtoRegE`, `MemWriteE`, `ALUSrcE`, `RegDstE` out 1 each: registered control.
- `ALUControlE` out 3: registered ALU operation.
- `RD1E`, `RD2E`, `SignImmE` out DW: registered data.
- `RsE`, `RtE`, `RdE` out RW: registered specifiers.
- `WriteRegE` out RW: destination register for E.
- `ValidE` out 1: E holds a real instruction.
- `BubbleCnt` out 32: count of inserted bubbles.
- `InstrCnt` out 32: count of valid instructions that entered E.

## Operation
- Three capture modes, with this priority per rising edge: `rst`, then `FlushE`, then normal capture.
- `rst`:
  - Every registered output goes to 0, including `ValidE`.
  - Both counters clear to 0.
- `FlushE` (with `rst`=0):
  - Loads a bubble: all control outputs 0, `ALUControlE`=0, `RsE`/`RtE`/`RdE`=0, `RD1E`/`RD2E`/`SignImmE`=0, `ValidE`=0.
  - Zeroed `RsE`/`RtE` guarantee that no forward selects a bubble (register 0 is never forwarded).
  - `MemtoRegE`=0 guarantees that a bubble cannot re-trigger a load-use stall on the next cycle.
- Normal capture: every E output takes its D counterpart; `ValidE` takes `ValidD`.
- `WriteRegE` is combinational from registered state: `RegDstE ? RdE : RtE`. It is 0 after reset or flush.
- No stall input exists. E never holds; a D stall is always paired with `FlushE`.
- Control outputs are not gated by `ValidD`. Decode drives zero control for invalid slots.

## Timing
- Latency: 1 cycle. D values at edge N are visible on E outputs after edge N.
- `FlushE` takes effect at the same edge it is sampled. The instruction held in D is re-captured on the following edge, when `FlushE` is normally 0.
- Back-to-back `FlushE` produces consecutive bubbles; each increments `BubbleCnt`.
- `rst` asserted mid-operation discards the E contents and the counts on that edge. The first capture happens on the edge after `rst` deasserts.
- All outputs are registered except `WriteRegE`, which is a single 2:1 mux after the flops.

## Configuration
- Macro: `ID_EX_PERF_EN`.
- Defined:
  - `BubbleCnt` increments on every edge with `rst`=0 and `FlushE`=1.
  - `InstrCnt` increments on every edge with `rst`=0, `FlushE`=0 and `ValidD`=1.
  - Both saturate at 0xFFFFFFFF; there is no wrap.
- Undefined:
  - No counter flops are built.
  - `BubbleCnt` and `InstrCnt` are tied to constant 0.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with all D inputs at 1s → every output 0, `WriteRegE`=0, counters 0.
- Capture: `RD1D`=0x12345678, `RsD`=3, `RtD`=5, `RdD`=9, `RegDstD`=1, `RegWriteD`=1, `ValidD`=1 → next cycle `RD1E`=0x12345678, `RsE`=3, `RtE`=5, `WriteRegE`=9, `ValidE`=1. With `RegDstD`=0 → `WriteRegE`=5.
- Load-use bubble: `MemtoRegD`=1 (lw, `RtD`=7) captured; next cycle `FlushE`=1 → following cycle `MemtoRegE`=0, `RtE`=0, `RegWriteE`=0, `ValidE`=0. `BubbleCnt`=1 with `ID_EX_PERF_EN`, 0 without.
- Priority: `rst`=1 and `FlushE`=1 on the same edge → all outputs 0, `BubbleCnt` stays 0.
- Counter saturation (`ID_EX_PERF_EN`): force `InstrCnt` to 0xFFFFFFFE, capture 3 valid instructions → `InstrCnt`=0xFFFFFFFF, held.
- Reset mid-stream: 10 valid captures, then `rst` for 1 cycle → `InstrCnt`=0, `ValidE`=0. The next valid capture gives `InstrCnt`=1.

Source files
------------

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register: 1-cycle latency, no hold path (a D stall is always paired with a FlushE bubble).
// Optional bubble/instruction performance counters are built only when ID_EX_PERF_EN is defined.
module id_ex_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          FlushE,
  input  logic          ValidD,
  input  logic          RegWriteD,
  input  logic          MemtoRegD,
  input  logic          MemWriteD,
  input  logic          ALUSrcD,
  input  logic          RegDstD,
  input  logic [2:0]    ALUControlD,
  input  logic [DW-1:0] RD1D,
  input  logic [DW-1:0] RD2D,
  input  logic [DW-1:0] SignImmD,
  input  logic [RW-1:0] RsD,
  input  logic [RW-1:0] RtD,
  input  logic [RW-1:0] RdD,
  output logic          RegWriteE,
  output logic          MemtoRegE,
  output logic          MemWriteE,
  output logic          ALUSrcE,
  output logic          RegDstE,
  output logic [2:0]    ALUControlE,
  output logic [DW-1:0] RD1E,
  output logic [DW-1:0] RD2E,
  output logic [DW-1:0] SignImmE,
  output logic [RW-1:0] RsE,
  output logic [RW-1:0] RtE,
  output logic [RW-1:0] RdE,
  output logic [RW-1:0] WriteRegE,
  output logic          ValidE,
  output logic [31:0]   BubbleCnt,
  output logic [31:0]   InstrCnt
);

  logic          reg_write_d,  reg_write_q;
  logic          mem_to_reg_d, mem_to_reg_q;
  logic          mem_write_d,  mem_write_q;
  logic          alu_src_d,    alu_src_q;
  logic          reg_dst_d,    reg_dst_q;
  logic [2:0]    alu_ctrl_d,   alu_ctrl_q;
  logic [DW-1:0] rd1_d,        rd1_q;
  logic [DW-1:0] rd2_d,        rd2_q;
  logic [DW-1:0] sign_imm_d,   sign_imm_q;
  logic [RW-1:0] rs_d,         rs_q;
  logic [RW-1:0] rt_d,         rt_q;
  logic [RW-1:0] rd_d,         rd_q;
  logic          valid_d,      valid_q;

  // A bubble zeroes Rs/Rt (never forwarded) and MemtoReg (cannot re-trigger a load-use stall).
  always_comb begin
    reg_write_d  = RegWriteD;
    mem_to_reg_d = MemtoRegD;
    mem_write_d  = MemWriteD;
    alu_src_d    = ALUSrcD;
    reg_dst_d    = RegDstD;
    alu_ctrl_d   = ALUControlD;
    rd1_d        = RD1D;
    rd2_d        = RD2D;
    sign_imm_d   = SignImmD;
    rs_d         = RsD;
    rt_d         = RtD;
    rd_d         = RdD;
    valid_d      = ValidD;
    if (FlushE) begin
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      alu_src_d    = 1'b0;
      reg_dst_d    = 1'b0;
      alu_ctrl_d   = '0;
      rd1_d        = '0;
      rd2_d        = '0;
      sign_imm_d   = '0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
      valid_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_ctrl_q   <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      sign_imm_q   <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      valid_q      <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      alu_src_q    <= alu_src_d;
      reg_dst_q    <= reg_dst_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      sign_imm_q   <= sign_imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      valid_q      <= valid_d;
    end
  end

  assign RegWriteE   = reg_write_q;
  assign MemtoRegE   = mem_to_reg_q;
  assign MemWriteE   = mem_write_q;
  assign ALUSrcE     = alu_src_q;
  assign RegDstE     = reg_dst_q;
  assign ALUControlE = alu_ctrl_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign SignImmE    = sign_imm_q;
  assign RsE         = rs_q;
  assign RtE         = rt_q;
  assign RdE         = rd_q;
  assign ValidE      = valid_q;
  assign WriteRegE   = reg_dst_q ? rd_q : rt_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;
  logic [31:0] instr_cnt_d,  instr_cnt_q;

  // Saturating counters: stick at all-ones rather than wrap.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    instr_cnt_d  = instr_cnt_q;
    if (FlushE) begin
      if (bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else if (ValidD) begin
      if (instr_cnt_q != 32'hFFFF_FFFF) instr_cnt_d = instr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      instr_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  assign BubbleCnt = bubble_cnt_q;
  assign InstrCnt  = instr_cnt_q;
`else
  assign BubbleCnt = 32'd0;
  assign InstrCnt  = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboarded directed bench for id_ex_reg; counter expectations follow ID_EX_PERF_EN.
module tb_id_ex_reg;

`ifdef ID_EX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        alusrc;
    logic        regdst;
    logic [2:0]  aluc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        vld;
  } word_t;

  typedef struct packed {
    word_t       w;
    logic [4:0]  wr;
    logic [31:0] bc;
    logic [31:0] ic;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic FlushE = 1'b0;
  word_t din = '0;

  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE, BubbleCnt, InstrCnt;
  logic [4:0]  RsE, RtE, RdE, WriteRegE;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_reg #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .FlushE(FlushE), .ValidD(din.vld),
    .RegWriteD(din.rw), .MemtoRegD(din.m2r), .MemWriteD(din.mw),
    .ALUSrcD(din.alusrc), .RegDstD(din.regdst), .ALUControlD(din.aluc),
    .RD1D(din.rd1), .RD2D(din.rd2), .SignImmD(din.imm),
    .RsD(din.rs), .RtD(din.rt), .RdD(din.rd),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .WriteRegE(WriteRegE),
    .ValidE(ValidE), .BubbleCnt(BubbleCnt), .InstrCnt(InstrCnt)
  );

  function automatic word_t mk(input logic rw, m2r, mw, alusrc, regdst,
                               input logic [2:0] aluc, input logic [31:0] rd1, rd2, imm,
                               input logic [4:0] rs, rt, rd, input logic vld);
    word_t w;
    w.rw = rw; w.m2r = m2r; w.mw = mw; w.alusrc = alusrc; w.regdst = regdst;
    w.aluc = aluc; w.rd1 = rd1; w.rd2 = rd2; w.imm = imm;
    w.rs = rs; w.rt = rt; w.rd = rd; w.vld = vld;
    return w;
  endfunction

  function automatic exp_t ex(input word_t w, input logic [4:0] wr, input int b, input int i);
    exp_t e;
    e.w  = w;
    e.wr = wr;
    e.bc = PERF ? 32'(b) : 32'd0;
    e.ic = PERF ? 32'(i) : 32'd0;
    return e;
  endfunction

  function automatic exp_t exu(input word_t w, input logic [4:0] wr, input logic [31:0] b, input logic [31:0] i);
    exp_t e;
    e.w = w; e.wr = wr;
    e.bc = PERF ? b : 32'd0;
    e.ic = PERF ? i : 32'd0;
    return e;
  endfunction

  // Called at a falling edge; drives D side, queues the response expected after the next rising edge.
  task automatic step(input word_t d, input logic r, input logic f, input exp_t e);
    din = d;
    rst = r;
    FlushE = f;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every rising edge with an outstanding expectation is checked 1ns later.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a.w  = {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
                RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE};
        a.wr = WriteRegE;
        a.bc = BubbleCnt;
        a.ic = InstrCnt;
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL cmp#%0d t=%0t: got ctl=%b alu=%0d rd1=%h rd2=%h imm=%h rs=%0d rt=%0d rd=%0d wr=%0d vld=%b bc=%h ic=%h | want ctl=%b alu=%0d rd1=%h rd2=%h imm=%h rs=%0d rt=%0d rd=%0d wr=%0d vld=%b bc=%h ic=%h",
                   n_cmp, $time,
                   {a.w.rw, a.w.m2r, a.w.mw, a.w.alusrc, a.w.regdst}, a.w.aluc, a.w.rd1, a.w.rd2, a.w.imm,
                   a.w.rs, a.w.rt, a.w.rd, a.wr, a.w.vld, a.bc, a.ic,
                   {e.w.rw, e.w.m2r, e.w.mw, e.w.alusrc, e.w.regdst}, e.w.aluc, e.w.rd1, e.w.rd2, e.w.imm,
                   e.w.rs, e.w.rt, e.w.rd, e.wr, e.w.vld, e.bc, e.ic);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t z, ones, wa, wb, wlw, wadd, winv, wl;
    z    = '0;
    ones = '1;
    wa   = mk(1, 0, 0, 0, 1, 3'd2, 32'h1234_5678, 32'hCAFE_BABE, 32'hFFFF_FFF0, 5'd3, 5'd5, 5'd9, 1);
    wb   = mk(1, 0, 0, 1, 0, 3'd6, 32'h1234_5678, 32'h0000_0011, 32'h0000_0020, 5'd3, 5'd5, 5'd9, 1);
    wlw  = mk(1, 1, 0, 1, 0, 3'd2, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0004, 5'd2, 5'd7, 5'd0, 1);
    wadd = mk(1, 0, 0, 0, 1, 3'd2, 32'h0000_0003, 32'h0000_0004, 32'h0000_3820, 5'd7, 5'd8, 5'd10, 1);
    winv = mk(0, 0, 0, 0, 0, 3'd0, 32'hAAAA_5555, 32'h5555_AAAA, 32'h0000_0001, 5'd4, 5'd6, 5'd11, 0);

    @(negedge clk);
    // Reset with all D inputs high: everything stays 0.
    step(ones, 1, 0, ex(z, 5'd0, 0, 0));
    step(ones, 1, 0, ex(z, 5'd0, 0, 0));
    // Capture with RegDst=1 then RegDst=0.
    step(wa, 0, 0, ex(wa, 5'd9, 0, 1));
    step(wb, 0, 0, ex(wb, 5'd5, 0, 2));
    // Load-use: lw captured, then a bubble while D holds the dependent add, then the add.
    step(wlw, 0, 0, ex(wlw, 5'd7, 0, 3));
    step(wadd, 0, 1, ex(z, 5'd0, 1, 3));
    step(wadd, 0, 0, ex(wadd, 5'd10, 1, 4));
    // Back-to-back bubbles.
    step(wa, 0, 1, ex(z, 5'd0, 2, 4));
    step(wa, 0, 1, ex(z, 5'd0, 3, 4));
    // Invalid slot: data still captured, ValidE low, InstrCnt unchanged.
    step(winv, 0, 0, ex(winv, 5'd6, 3, 4));
    // rst beats FlushE on the same edge.
    step(ones, 1, 1, ex(z, 5'd0, 0, 0));
    // Ten valid captures then a mid-stream reset.
    for (int i = 1; i <= 10; i++) begin
      wl = mk(1, 0, 0, 0, i[0], 3'(i), 32'(i) * 32'h1111, 32'(i), 32'(100 + i),
              5'(i), 5'(i + 1), 5'(i + 2), 1);
      step(wl, 0, 0, ex(wl, i[0] ? 5'(i + 2) : 5'(i + 1), 0, i));
    end
    step(wa, 1, 0, ex(z, 5'd0, 0, 0));
    step(wb, 0, 0, ex(wb, 5'd5, 0, 1));
`ifdef ID_EX_PERF_EN
    // Saturation: InstrCnt preloaded to all-ones minus one.
    force dut.instr_cnt_q = 32'hFFFF_FFFE;
    release dut.instr_cnt_q;
    step(wa, 0, 0, exu(wa, 5'd9, 32'd0, 32'hFFFF_FFFF));
    step(wb, 0, 0, exu(wb, 5'd5, 32'd0, 32'hFFFF_FFFF));
    step(wa, 0, 0, exu(wa, 5'd9, 32'd0, 32'hFFFF_FFFF));
`endif
    din = z;
    FlushE = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
